// File: rtl/normalise_sum.sv
// Two-stage normaliser: turns the adder's unnormalised significand/exponent into a packed
// IEEE-754 single (round-to-nearest-even, denormals, infinity), carrying CORDIC sidebands along.
module normalise_sum #(
    parameter logic [1:0] mode_circular   = 2'b01,
    parameter logic [1:0] mode_linear     = 2'b00,
    parameter logic [1:0] mode_hyperbolic = 2'b11,
    parameter logic [1:0] no_idle         = 2'b00,
    parameter logic [1:0] allign_idle     = 2'b01,
    parameter logic [1:0] put_idle        = 2'b10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  idle_AddState,
    input  logic [31:0] sout_AddState,
    input  logic [27:0] sum_AddState,
    input  logic [1:0]  modeout_AddState,
    input  logic        operationout_AddState,
    input  logic        NatLogFlagout_AddState,
    input  logic [7:0]  InsTag_AddState,
    output logic [1:0]  idle_NormaliseSum,
    output logic [31:0] sout_NormaliseSum,
    output logic [1:0]  modeout_NormaliseSum,
    output logic        operationout_NormaliseSum,
    output logic        NatLogFlagout_NormaliseSum,
    output logic [7:0]  InsTag_NormaliseSum
);

    function automatic logic [4:0] count_lz(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

    // Ties go to even: bit 3 is the LSB that survives.
    function automatic logic [24:0] round_rne(input logic [26:0] n);
        logic inc;
        inc = n[2] & (n[1] | n[0] | n[3]);
        return {1'b0, n[26:3]} + {24'd0, inc};
    endfunction

    function automatic logic [31:0] pack_result(input logic sign,
                                                input logic signed [9:0] e2,
                                                input logic [26:0] n);
        logic [24:0]       sig25;
        logic [23:0]       sig;
        logic signed [9:0] e_adj;
        logic signed [9:0] biased;
        sig25 = round_rne(n);
        if (sig25[24]) begin
            sig   = 24'h800000;
            e_adj = e2 + 10'sd1;
        end else begin
            sig   = sig25[23:0];
            e_adj = e2;
        end
        biased = e_adj + 10'sd127;
        if (biased >= 10'sd255)
            return {sign, 8'hFF, 23'h0};
        else if (sig[23] && (biased > 10'sd0))
            return {sign, biased[7:0], sig[22:0]};
        else
            return {sign, 8'h00, sig[22:0]};
    endfunction

    logic signed [9:0] exp_in;
    logic [26:0]       m_d;
    logic signed [9:0] e_d;
    logic [4:0]        lz_d;

    assign exp_in = {{2{sout_AddState[30]}}, sout_AddState[30:23]};

    always_comb begin
        if (sum_AddState[27]) begin
            m_d  = {sum_AddState[27:2], sum_AddState[1] | sum_AddState[0]};
            e_d  = exp_in + 10'sd1;
            lz_d = 5'd0;
        end else begin
            m_d  = sum_AddState[26:0];
            e_d  = exp_in;
            lz_d = count_lz(sum_AddState[26:0]);
        end
    end

    // ---- stage 1: pre-normalised significand, exponent, leading-zero count ----
    logic [1:0]        idle_p1;
    logic [31:0]       sout_p1;
    logic [26:0]       m_p1;
    logic signed [9:0] e_p1;
    logic [4:0]        lz_p1;
    logic              sign_p1;
    logic              zero_p1;
    logic [1:0]        mode_p1;
    logic              op_p1;
    logic              nat_p1;
    logic [7:0]        tag_p1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_p1 <= put_idle;
            sout_p1 <= '0;
            m_p1    <= '0;
            e_p1    <= '0;
            lz_p1   <= '0;
            sign_p1 <= 1'b0;
            zero_p1 <= 1'b0;
            mode_p1 <= '0;
            op_p1   <= 1'b0;
            nat_p1  <= 1'b0;
            tag_p1  <= '0;
        end else begin
            idle_p1 <= idle_AddState;
            sout_p1 <= sout_AddState;
            m_p1    <= m_d;
            e_p1    <= e_d;
            lz_p1   <= lz_d;
            sign_p1 <= sout_AddState[31];
            zero_p1 <= (sum_AddState == 28'd0);
            mode_p1 <= modeout_AddState;
            op_p1   <= operationout_AddState;
            nat_p1  <= NatLogFlagout_AddState;
            tag_p1  <= InsTag_AddState;
        end
    end

    logic signed [9:0] e_lz_p1;
    logic signed [9:0] e_room_p1;
    logic signed [9:0] e2_p1;
    logic [4:0]        sh_p1;
    logic [26:0]       n_p1;
    logic [31:0]       result_p1;

    // Shift is capped so the exponent never drops below -126; the rest stays denormal.
    always_comb begin
        e_lz_p1   = e_p1 - $signed({5'd0, lz_p1});
        e_room_p1 = e_p1 + 10'sd126;
        sh_p1     = lz_p1;
        if (e_lz_p1 < -10'sd126)
            sh_p1 = (e_room_p1 < 10'sd0) ? 5'd0 : e_room_p1[4:0];
        n_p1  = m_p1 << sh_p1;
        e2_p1 = e_p1 - $signed({5'd0, sh_p1});
        if ((idle_p1 != no_idle) && (idle_p1 != allign_idle))
            result_p1 = sout_p1;
        else if (zero_p1)
            result_p1 = 32'h0;
        else
            result_p1 = pack_result(sign_p1, e2_p1, n_p1);
    end

    // ---- stage 2: rounded, packed result ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_NormaliseSum          <= put_idle;
            sout_NormaliseSum          <= '0;
            modeout_NormaliseSum       <= '0;
            operationout_NormaliseSum  <= 1'b0;
            NatLogFlagout_NormaliseSum <= 1'b0;
            InsTag_NormaliseSum        <= '0;
        end else begin
            idle_NormaliseSum          <= idle_p1;
            sout_NormaliseSum          <= result_p1;
            modeout_NormaliseSum       <= mode_p1;
            operationout_NormaliseSum  <= op_p1;
            NatLogFlagout_NormaliseSum <= nat_p1;
            InsTag_NormaliseSum        <= tag_p1;
        end
    end

endmodule

// File: doc/normalise_sum.md
NORMALISE_SUM -- requirements
Module: normalise_sum

Interface
REQ-001 SHALL have parameters: mode_circular 2'b01, circular mode code; mode_linear 2'b00, linear mode code; mode_hyperbolic 2'b11, hyperbolic mode code; no_idle 2'b00, active token; allign_idle 2'b01, align-idle token; put_idle 2'b10, pass-through bubble token.
REQ-002 SHALL have ports (clock and reset first):
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- idle_AddState  in  2  idle code from add stage.
- sout_AddState  in  32  [31] sign, [30:23] unbiased exponent (8-bit two's complement), [22:0] don't-care; whole word is the operand when idle = put_idle.
- sum_AddState  in  28  [27] carry, [26] hidden bit, [25:3] fraction, [2] guard, [1] round, [0] sticky.
- modeout_AddState  in  2  CORDIC mode.
- operationout_AddState  in  1  operation flag.
- NatLogFlagout_AddState  in  1  natural-log flag.
- InsTag_AddState  in  8  instruction tag.
- idle_NormaliseSum  out  2  delayed idle code.
- sout_NormaliseSum  out  32  packed IEEE-754 single result.
- modeout_NormaliseSum, operationout_NormaliseSum, NatLogFlagout_NormaliseSum, InsTag_NormaliseSum  out  2/1/1/8  delayed sidebands.
REQ-003 SHALL use one clock; reset asynchronous, active-high.

Function
REQ-004 SHALL be a two-stage pipeline: every input accepted each cycle; outputs valid exactly 2 clocks later; no stall, no handshake.
REQ-005 SHALL carry idle, mode, operation, NatLogFlag and InsTag through both stages unchanged and aligned with their data.
REQ-006 Stage 1, sum[27]=1: m = sum[27:1] with m[0] = sum[1]|sum[0]; e = sext10(exp)+1.
REQ-007 Stage 1, sum[27]=0: m = sum[26:0]; e = sext10(exp); lz = leading-zero count of sum[26:0] (0..27; 27 means zero).
REQ-008 Stage 1 SHALL register m, e, lz, sign and a zero flag (sum = 0).
REQ-009 Stage 2 shift sh = lz, but if e-lz < -126 then sh = max(e+126, 0) and result denormal (biased exponent 0).
REQ-010 Stage 2 SHALL compute n = m << sh (27 bits, zero fill, overflow bits dropped), e2 = e-sh.
REQ-011 Rounding SHALL be round-to-nearest-even: increment n[26:3] when n[2] & (n[1] | n[0] | n[3]).
REQ-012 When rounding carries out of 24 bits, significand SHALL become 24'h800000 and e2 increments by 1 (denormal rounding into bit 23 gives biased exponent 1).
REQ-013 Pack: sout = {sign, e2+127 (8 bits), rounded fraction[22:0]}.
REQ-014 e2+127 >= 255 SHALL pack {sign, 8'hFF, 23'h0} (infinity).
REQ-015 Zero flag SHALL force sout = 32'h00000000 regardless of sign.
REQ-016 idle = put_idle SHALL pass sout_AddState to sout_NormaliseSum unmodified after 2 clocks and ignore sum.
REQ-017 idle = no_idle and allign_idle SHALL both be normalised identically.
REQ-018 Arithmetic SHALL use 10-bit signed exponent internally; no wrap of e before REQ-014 check.

Reset
REQ-019 reset high SHALL immediately clear all pipeline registers and outputs to 0, except idle_NormaliseSum and stage-1 idle set to put_idle (2'b10).
REQ-020 First valid output after reset deassertion SHALL appear 2 rising edges after the first captured input; no partial results from pre-reset data.

Verification
REQ-021 idle 00, sign 0, exp 8'h00, sum 28'h4000000 -> sout 32'h3F800000 two clocks later.
REQ-022 sum 28'h8000000, exp 8'h00 -> 32'h40000000; sum 28'h0400000, exp 8'h00 (lz 4) -> 32'h3D800000.
REQ-023 Rounding: sum 28'h4000004 -> 32'h3F800000 (tie, even); sum 28'h400000C -> 32'h3F800002; sum 28'h7FFFFFC -> 32'h40000000.
REQ-024 sum 28'h0, sign 1 -> 32'h00000000; exp 8'h7F, sum 28'h8000000 -> 32'h7F800000.
REQ-025 idle 10, sout 32'hDEADBEEF, InsTag 8'h5A -> after 2 clocks sout 32'hDEADBEEF, idle 10, InsTag 8'h5A; back-to-back inputs every cycle emerge in order.
REQ-026 Reset asserted with both stages full -> outputs 0 / idle 10 same cycle, before next edge; post-release result follows REQ-020.
